fifo_mux_top: RTL and testbench



---
 rtl/fifo_mux_top.sv | 226 ++++++++++++++++++++++
 tb/tb_fifo_mux_top.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mux_top.sv
// fifo_mux_top
//
// Integration top of the project datapath. A 4-bit, 8-entry input FIFO (IF)
// feeds a 4-bit, 8-entry output FIFO (OF). Around them sits a selectable
// routing fabric:
//   - two one-hot-style lane demultiplexers (lane vectors A and B),
//   - a two-word crossbar producing W0/W1 from DEMUX17/DEMUX18,
//   - source muxes choosing the IF write word and the IF->OF transfer word,
//   - four output muxes whose results are registered.
//
// Ports
//   inClock                  sole clock, rising edge
//   inReset                  synchronous, active-low reset
//   in_inFIFO_inData  [3:0]  candidate IF write word (written every cycle)
//   in_outFIFO_inReadEnable  OF pop request
//   in_DEMUX_inDEMUX1/2      bits steered into lane vectors A / B
//   in_DEMUX_inDEMUX17/18    crossbar word inputs
//   in_DEMUX_inSEL1/2  [2:0] lane index for A / B
//   in_MUX_inSEL3            IF write source (0 = inData, 1 = W0)
//   in_MUX_inSEL6     [1:0]  outMUX9 source
//   in_MUX_inSEL9     [1:0]  outMUX10 source
//   in_MUX_inSEL11           outMUX16 source (1 = OF empty flag)
//   in_MUX_inSEL12           transfer source (0 = IF head, 1 = W1)
//   in_MUX_inSEL15    [2:0]  lane index for outMUX15/outMUX16
//   in_DEMUX_inSEL17         crossbar swap
//   out_MUX_outMUX9/10 [3:0] registered word outputs
//   out_MUX_outMUX15/16      registered bit outputs
module fifo_mux_top (
  input  logic       inClock,
  input  logic       inReset,
  input  logic [3:0] in_inFIFO_inData,
  input  logic       in_outFIFO_inReadEnable,
  input  logic       in_DEMUX_inDEMUX1,
  input  logic       in_DEMUX_inDEMUX2,
  input  logic [3:0] in_DEMUX_inDEMUX17,
  input  logic [3:0] in_DEMUX_inDEMUX18,
  input  logic [2:0] in_DEMUX_inSEL1,
  input  logic [2:0] in_DEMUX_inSEL2,
  input  logic       in_MUX_inSEL3,
  input  logic [1:0] in_MUX_inSEL6,
  input  logic [1:0] in_MUX_inSEL9,
  input  logic       in_MUX_inSEL11,
  input  logic       in_MUX_inSEL12,
  input  logic [2:0] in_MUX_inSEL15,
  input  logic       in_DEMUX_inSEL17,
  output logic [3:0] out_MUX_outMUX9,
  output logic [3:0] out_MUX_outMUX10,
  output logic       out_MUX_outMUX15,
  output logic       out_MUX_outMUX16
);

  localparam logic [3:0] FifoDepth = 4'd8;

  // Routing fabric signals
  logic [7:0] laneA;
  logic [7:0] laneB;
  logic [3:0] word0;
  logic [3:0] word1;

  // Input FIFO state
  logic [3:0] ifMem [8];
  logic [2:0] ifRdPtr;
  logic [2:0] ifWrPtr;
  logic [3:0] ifCount;
  logic       ifEmpty;
  logic       ifFull;
  logic [3:0] ifHead;
  logic [3:0] ifWrData;
  logic       ifPush;

  // Output FIFO state
  logic [3:0] ofMem [8];
  logic [2:0] ofRdPtr;
  logic [2:0] ofWrPtr;
  logic [3:0] ofCount;
  logic       ofEmpty;
  logic       ofFull;
  logic [3:0] ofHead;
  logic       ofPop;
  logic       ofCanAccept;

  // Transfer between the FIFOs
  logic       xfer;
  logic [3:0] xferData;

  // Output mux selections before registering
  logic [3:0] mux9Next;
  logic [3:0] mux10Next;
  logic       mux15Next;
  logic       mux16Next;

  // Lane vectors: exactly one bit position (chosen by the lane index) carries
  // the demux input bit, every other position is held at 0.
  always_comb begin
    laneA = 8'd0;
    laneB = 8'd0;
    laneA[in_DEMUX_inSEL1] = in_DEMUX_inDEMUX1;
    laneB[in_DEMUX_inSEL2] = in_DEMUX_inDEMUX2;
  end

  // Crossbar: straight-through when SEL17 is low, swapped when high.
  always_comb begin
    if (in_DEMUX_inSEL17) begin
      word0 = in_DEMUX_inDEMUX18;
      word1 = in_DEMUX_inDEMUX17;
    end else begin
      word0 = in_DEMUX_inDEMUX17;
      word1 = in_DEMUX_inDEMUX18;
    end
  end

  // FIFO status flags and first-word-fall-through heads. An empty FIFO
  // presents 0 rather than stale memory contents.
  always_comb begin
    ifEmpty = (ifCount == 4'd0);
    ifFull  = (ifCount == FifoDepth);
    ofEmpty = (ofCount == 4'd0);
    ofFull  = (ofCount == FifoDepth);
    ifHead  = ifEmpty ? 4'd0 : ifMem[ifRdPtr];
    ofHead  = ofEmpty ? 4'd0 : ofMem[ofRdPtr];
  end

  // Handshake between the two FIFOs. The decisions chain from the output
  // side backwards: an OF pop frees a slot for the transfer, and the transfer
  // in turn frees an IF slot, so a full pipeline still moves one word per
  // cycle. The IF has no write enable: a word is offered every cycle and is
  // silently dropped when there is no room.
  always_comb begin
    ofPop       = in_outFIFO_inReadEnable && !ofEmpty;
    ofCanAccept = !ofFull || ofPop;
    xfer        = !ifEmpty && ofCanAccept;
    ifPush      = !ifFull || xfer;
    ifWrData    = in_MUX_inSEL3 ? word0 : in_inFIFO_inData;
    xferData    = in_MUX_inSEL12 ? word1 : ifHead;
  end

  // Input FIFO storage. Kept free of reset; the heads are masked by the
  // empty flag so stale contents never reach the outputs.
  always_ff @(posedge inClock) begin
    if (inReset && ifPush) begin
      ifMem[ifWrPtr] <= ifWrData;
    end
  end

  // Input FIFO pointers and occupancy. A push and a pop in the same cycle
  // leave the count unchanged, including when the FIFO is full.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      ifRdPtr <= 3'd0;
      ifWrPtr <= 3'd0;
      ifCount <= 4'd0;
    end else begin
      if (ifPush) begin
        ifWrPtr <= ifWrPtr + 3'd1;
      end
      if (xfer) begin
        ifRdPtr <= ifRdPtr + 3'd1;
      end
      ifCount <= ifCount + {3'd0, ifPush} - {3'd0, xfer};
    end
  end

  // Output FIFO storage, written by the transfer path.
  always_ff @(posedge inClock) begin
    if (inReset && xfer) begin
      ofMem[ofWrPtr] <= xferData;
    end
  end

  // Output FIFO pointers and occupancy. Reads on an empty FIFO were already
  // filtered out when forming ofPop.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      ofRdPtr <= 3'd0;
      ofWrPtr <= 3'd0;
      ofCount <= 4'd0;
    end else begin
      if (xfer) begin
        ofWrPtr <= ofWrPtr + 3'd1;
      end
      if (ofPop) begin
        ofRdPtr <= ofRdPtr + 3'd1;
      end
      ofCount <= ofCount + {3'd0, xfer} - {3'd0, ofPop};
    end
  end

  // Output mux selection. Everything here reflects the state before the
  // coming edge, so the registered outputs show it one edge later.
  always_comb begin
    mux9Next = 4'd0;
    case (in_MUX_inSEL6)
      2'd0:    mux9Next = ofHead;
      2'd1:    mux9Next = ifHead;
      2'd2:    mux9Next = word0;
      default: mux9Next = word1;
    endcase

    mux10Next = 4'd0;
    case (in_MUX_inSEL9)
      2'd0:    mux10Next = word1;
      2'd1:    mux10Next = ofHead;
      2'd2:    mux10Next = laneA[3:0];
      default: mux10Next = laneB[3:0];
    endcase

    mux15Next = laneA[in_MUX_inSEL15];
    mux16Next = in_MUX_inSEL11 ? ofEmpty : laneB[in_MUX_inSEL15];
  end

  // Output registers, cleared by reset.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      out_MUX_outMUX9  <= 4'd0;
      out_MUX_outMUX10 <= 4'd0;
      out_MUX_outMUX15 <= 1'b0;
      out_MUX_outMUX16 <= 1'b0;
    end else begin
      out_MUX_outMUX9  <= mux9Next;
      out_MUX_outMUX10 <= mux10Next;
      out_MUX_outMUX15 <= mux15Next;
      out_MUX_outMUX16 <= mux16Next;
    end
  end

endmodule

// File: tb/tb_fifo_mux_top.sv
// tb_fifo_mux_top
//
// Self-checking bench for fifo_mux_top. A queue-based reference model tracks
// the two FIFOs and predicts all four registered outputs every cycle; the
// directed steps add literal expectations for the key scenarios.
module tb_fifo_mux_top;

  logic       clk;
  logic       rst;
  logic [3:0] inData;
  logic       readEnable;
  logic       demux1;
  logic       demux2;
  logic [3:0] demux17;
  logic [3:0] demux18;
  logic [2:0] sel1;
  logic [2:0] sel2;
  logic       sel3;
  logic [1:0] sel6;
  logic [1:0] sel9;
  logic       sel11;
  logic       sel12;
  logic [2:0] sel15;
  logic       sel17;
  logic [3:0] outMux9;
  logic [3:0] outMux10;
  logic       outMux15;
  logic       outMux16;

  // Reference model state
  logic [3:0] ifQ[$];
  logic [3:0] ofQ[$];
  logic [3:0] exp9;
  logic [3:0] exp10;
  logic       exp15;
  logic       exp16;

  int vectors;
  int miscompares;

  fifo_mux_top dut (
    .inClock                 (clk),
    .inReset                 (rst),
    .in_inFIFO_inData        (inData),
    .in_outFIFO_inReadEnable (readEnable),
    .in_DEMUX_inDEMUX1       (demux1),
    .in_DEMUX_inDEMUX2       (demux2),
    .in_DEMUX_inDEMUX17      (demux17),
    .in_DEMUX_inDEMUX18      (demux18),
    .in_DEMUX_inSEL1         (sel1),
    .in_DEMUX_inSEL2         (sel2),
    .in_MUX_inSEL3           (sel3),
    .in_MUX_inSEL6           (sel6),
    .in_MUX_inSEL9           (sel9),
    .in_MUX_inSEL11          (sel11),
    .in_MUX_inSEL12          (sel12),
    .in_MUX_inSEL15          (sel15),
    .in_DEMUX_inSEL17        (sel17),
    .out_MUX_outMUX9         (outMux9),
    .out_MUX_outMUX10        (outMux10),
    .out_MUX_outMUX15        (outMux15),
    .out_MUX_outMUX16        (outMux16)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point used by every check
  task automatic checkValue(input string tag, input logic [3:0] observed,
                            input logic [3:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare all outputs against the model prediction
  task automatic checkOutput();
    checkValue("outMUX9", outMux9, exp9);
    checkValue("outMUX10", outMux10, exp10);
    checkValue("outMUX15", {3'd0, outMux15}, {3'd0, exp15});
    checkValue("outMUX16", {3'd0, outMux16}, {3'd0, exp16});
  endtask

  // Bit of a lane vector: only the indexed position carries the input bit
  function automatic logic laneBit(input int pos, input logic [2:0] sel,
                                   input logic v);
    return (pos == int'(sel)) ? v : 1'b0;
  endfunction

  // Predict one clock edge from the current inputs and model state, advance
  // the clock, then compare the outputs.
  task automatic applyStimulus();
    logic [3:0] w0, w1, ifHead, ofHead, wrWord, xferWord, laneA4, laneB4;
    logic       popOf, xferNow, pushIf;
    if (!rst) begin
      ifQ.delete();
      ofQ.delete();
      exp9  = 4'd0;
      exp10 = 4'd0;
      exp15 = 1'b0;
      exp16 = 1'b0;
    end else begin
      w0 = sel17 ? demux18 : demux17;
      w1 = sel17 ? demux17 : demux18;
      ifHead = (ifQ.size() > 0) ? ifQ[0] : 4'd0;
      ofHead = (ofQ.size() > 0) ? ofQ[0] : 4'd0;
      for (int i = 0; i < 4; i++) begin
        laneA4[i] = laneBit(i, sel1, demux1);
        laneB4[i] = laneBit(i, sel2, demux2);
      end
      case (sel6)
        2'd0: exp9 = ofHead;
        2'd1: exp9 = ifHead;
        2'd2: exp9 = w0;
        default: exp9 = w1;
      endcase
      case (sel9)
        2'd0: exp10 = w1;
        2'd1: exp10 = ofHead;
        2'd2: exp10 = laneA4;
        default: exp10 = laneB4;
      endcase
      exp15 = laneBit(int'(sel15), sel1, demux1);
      exp16 = sel11 ? (ofQ.size() == 0) : laneBit(int'(sel15), sel2, demux2);

      popOf    = readEnable && (ofQ.size() > 0);
      xferNow  = (ifQ.size() > 0) && ((ofQ.size() < 8) || popOf);
      pushIf   = (ifQ.size() < 8) || xferNow;
      wrWord   = sel3 ? w0 : inData;
      xferWord = sel12 ? w1 : ifHead;
      if (popOf) void'(ofQ.pop_front());
      if (xferNow) begin
        ofQ.push_back(xferWord);
        void'(ifQ.pop_front());
      end
      if (pushIf) ifQ.push_back(wrWord);
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clearInputs();
    inData = 4'd0; readEnable = 1'b0;
    demux1 = 1'b0; demux2 = 1'b0; demux17 = 4'd0; demux18 = 4'd0;
    sel1 = 3'd0; sel2 = 3'd0; sel3 = 1'b0; sel6 = 2'd0; sel9 = 2'd0;
    sel11 = 1'b0; sel12 = 1'b0; sel15 = 3'd0; sel17 = 1'b0;
  endtask

  task automatic resetCycles(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus();
    rst = 1'b1;
  endtask

  task automatic randomInputs();
    inData = 4'($urandom); readEnable = 1'($urandom);
    demux1 = 1'($urandom); demux2 = 1'($urandom);
    demux17 = 4'($urandom); demux18 = 4'($urandom);
    sel1 = 3'($urandom); sel2 = 3'($urandom); sel3 = 1'($urandom);
    sel6 = 2'($urandom); sel9 = 2'($urandom); sel11 = 1'($urandom);
    sel12 = 1'($urandom); sel15 = 3'($urandom); sel17 = 1'($urandom);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    clearInputs();
    exp9 = 4'd0; exp10 = 4'd0; exp15 = 1'b0; exp16 = 1'b0;

    // Reset held five cycles with inData = 5; outputs stay 0
    inData = 4'h5;
    resetCycles(5);
    checkValue("resetOut9", outMux9, 4'h0);
    checkValue("resetOut16", {3'd0, outMux16}, 4'h0);

    // First capture, transfer, then visible on outMUX9
    for (int i = 0; i < 3; i++) applyStimulus();
    checkValue("latencyOut9", outMux9, 4'h5);

    // Fill both FIFOs without reading; later words are dropped
    resetCycles(2);
    for (int i = 0; i < 24; i++) begin
      inData = 4'(i);
      applyStimulus();
    end

    // Drain: words come out 0..F in order
    readEnable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      inData = 4'($urandom);
      applyStimulus();
      checkValue("readSeq", outMux9, 4'(k));
    end
    readEnable = 1'b0;

    // Crossbar straight and swapped
    clearInputs();
    demux17 = 4'hA; demux18 = 4'h3; sel6 = 2'd2; sel9 = 2'd0;
    applyStimulus();
    checkValue("xbarW0", outMux9, 4'hA);
    checkValue("xbarW1", outMux10, 4'h3);
    sel17 = 1'b1;
    applyStimulus();
    checkValue("xbarSwapW0", outMux9, 4'h3);
    checkValue("xbarSwapW1", outMux10, 4'hA);

    // Lane sweep: outMUX15 set only when the indices agree
    clearInputs();
    demux1 = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        sel1 = 3'(a); sel15 = 3'(b);
        applyStimulus();
        checkValue("laneSweep", {3'd0, outMux15}, (a == b) ? 4'h1 : 4'h0);
      end
    end
    sel2 = 3'd2; demux2 = 1'b1; sel9 = 2'd3;
    applyStimulus();
    checkValue("laneB", outMux10, 4'b0100);

    // IF write source from W0 regardless of inData
    clearInputs();
    resetCycles(1);
    sel3 = 1'b1; demux17 = 4'h9; sel6 = 2'd1;
    for (int i = 0; i < 2; i++) begin
      inData = 4'($urandom);
      applyStimulus();
    end
    checkValue("sel3Source", outMux9, 4'h9);

    // Transfer source from W1 while IF keeps popping
    clearInputs();
    resetCycles(1);
    inData = 4'h1; sel12 = 1'b1; demux18 = 4'hC;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkValue("sel12Source", outMux9, 4'hC);

    // Mid-operation reset with partly full FIFOs
    clearInputs();
    for (int i = 0; i < 30; i++) begin
      randomInputs();
      readEnable = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end
    rst = 1'b0;
    applyStimulus();
    checkValue("midResetOut9", outMux9, 4'h0);
    checkValue("midResetOut10", outMux10, 4'h0);
    rst = 1'b1;
    clearInputs();
    sel11 = 1'b1;
    applyStimulus();
    checkValue("postResetHead", outMux9, 4'h0);
    checkValue("postResetEmpty", {3'd0, outMux16}, 4'h1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      rst = ($urandom_range(0, 39) != 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
